serial_adder: RTL
=================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH, default 4, operand and sum width in bits (legal range 2..16).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset; one clock, reset asynchronous and active-high.
REQ-004 start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 a  input  WIDTH  operand A, unsigned, captured on the accepted start edge.
REQ-006 b  input  WIDTH  operand B, unsigned, captured on the accepted start edge.
REQ-007 cin  input  1  carry-in, captured on the accepted start edge.
REQ-008 sum  output  WIDTH  registered result, valid from the done cycle until the next accepted start.
REQ-009 cout  output  1  registered carry-out, same validity as sum.
REQ-010 busy  output  1  high in SHIFT and DONE states.
REQ-011 done  output  1  one-cycle pulse marking sum/cout valid.

Function
REQ-012 The block SHALL compute {cout,sum} = a + b + cin bit-serially, LSB first, through one full-adder cell and one carry flip-flop.
REQ-013 The FSM SHALL have states IDLE, SHIFT and DONE.
REQ-014 IDLE with start=1 at an edge: load a_sr<=a, b_sr<=b, carry<=cin, bit counter<=0, sum<=0, cout<=0, go to SHIFT.
REQ-015 IDLE with start=0: hold all registers.
REQ-016 SHIFT, each edge: s=a_sr[0]^b_sr[0]^carry; carry<=majority(a_sr[0],b_sr[0],carry); shift s into sum from the MSB end; shift a_sr, b_sr right by 1; counter<=counter+1.
REQ-017 SHIFT SHALL last exactly WIDTH edges; on the edge where counter==WIDTH-1, go to DONE.
REQ-018 DONE: done=1 and cout=final carry for exactly one cycle, then unconditionally go to IDLE.
REQ-019 Latency: with start sampled at edge E0, done SHALL be high in the cycle after edge E0+WIDTH, i.e. WIDTH+1 cycles after start.
REQ-020 start SHALL be ignored in SHIFT and DONE; operands and state remain unaffected.
REQ-021 start held high continuously SHALL launch a new addition on the first edge after DONE, giving back-to-back operations every WIDTH+2 cycles.
REQ-022 sum and cout SHALL hold their value from DONE until the next accepted start clears them.
REQ-023 Changes on a, b or cin outside the accepted start edge SHALL NOT affect the result.

Reset
REQ-024 While rst=1, the FSM SHALL be in IDLE and all registers SHALL be 0: sum=0, cout=0, busy=0, done=0, carry=0, counter=0.
REQ-025 rst asserted mid-SHIFT or in DONE SHALL abort the operation immediately with no done pulse.
REQ-026 After rst deasserts, the first start SHALL be accepted normally.

Configuration
REQ-027 Macro SERIAL_ADDER_OVF_EN defined: add output ovf (1 bit, registered), equal to the carry into the MSB XOR the final carry (two's-complement overflow).
REQ-028 With SERIAL_ADDER_OVF_EN: ovf SHALL be valid and held with the same timing as cout, cleared on accepted start, and reset to 0.
REQ-029 Macro SERIAL_ADDER_OVF_EN undefined: the ovf port and its logic SHALL be absent; all other behaviour is unchanged.

Verification (WIDTH=4)
REQ-030 a=0, b=0, cin=0, start at E0 -> done high after E4, sum=0x0, cout=0, busy high for 5 cycles.
REQ-031 a=7, b=9, cin=0 -> sum=0x0, cout=1; a=15, b=15, cin=1 -> sum=0xF, cout=1.
REQ-032 start=1 again 2 cycles after an accepted start with a=1, b=1 -> ignored; the original result (3+4+0 -> sum=0x7, cout=0) is produced unchanged.
REQ-033 rst pulsed after 2 SHIFT edges -> sum=0, cout=0, busy=0, no done pulse; next start with a=2, b=3 -> sum=0x5.
REQ-034 start held high for 3 operations with a=5, b=6, cin=1 -> done pulses spaced 6 cycles apart, each with sum=0xC, cout=0.
REQ-035 With SERIAL_ADDER_OVF_EN: a=7, b=1 -> sum=0x8, ovf=1; a=15, b=1 -> sum=0x0, cout=1, ovf=0.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a carry flop, LSB first.
// Optional SERIAL_ADDER_OVF_EN adds a registered two's-complement ovf output.
module serial_adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] a_sr, b_sr;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             s, c_nx, last;

  assign s    = a_sr[0] ^ b_sr[0] ^ carry;
  assign c_nx = (a_sr[0] & b_sr[0]) |
                (a_sr[0] & carry) |
                (b_sr[0] & carry);
  assign last = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = SHIFT;
      SHIFT:   if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr  <= '0;
      b_sr  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            carry <= cin;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
          end
        end
        SHIFT: begin
          carry <= c_nx;
          sum   <= {s, sum[WIDTH-1:1]};
          a_sr  <= {1'b0, a_sr[WIDTH-1:1]};
          b_sr  <= {1'b0, b_sr[WIDTH-1:1]};
          cnt   <= cnt + 1'b1;
          if (last) begin
            cout <= c_nx;
`ifdef SERIAL_ADDER_OVF_EN
            // carry here is the carry into the MSB cell
            ovf  <= carry ^ c_nx;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

endmodule
